// File: rtl/render_scan_scheduler.sv
// Raster-order pixel scheduler: for every screen pixel it scans the block table serially
// through a synchronous read port, resolves doodle/block/background priority and emits one
// colored pixel per valid/ready handshake.
`timescale 1ns / 1ps

module render_scan_scheduler #(
  parameter int unsigned SCREEN_WIDTH  = 400,
  parameter int unsigned SCREEN_HEIGHT = 700,
  parameter int unsigned BLOCK_WIDTH   = 40,
  parameter int unsigned NUM_BLOCKS    = 16,
  parameter int unsigned ADDR_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       doodleX,
  input  logic [31:0]       doodleY,
  input  logic [31:0]       minY,
  output logic              blk_rd,
  output logic [ADDR_W-1:0] blk_addr,
  input  logic [31:0]       blk_x,
  input  logic [31:0]       blk_y,
  input  logic              blk_active,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [31:0]       pix_x,
  output logic [31:0]       pix_y,
  output logic [23:0]       pix_color,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [31:0]       XLast    = 32'(SCREEN_WIDTH - 1);
  localparam logic [31:0]       YLast    = 32'(SCREEN_HEIGHT - 1);
  localparam logic [31:0]       BlkW     = 32'(BLOCK_WIDTH);
  localparam logic [ADDR_W-1:0] LastK    = ADDR_W'(NUM_BLOCKS - 1);
  localparam logic [23:0]       ColBkgnd = 24'h0FAF0F;
  localparam logic [23:0]       ColBlock = 24'hFF000F;
  localparam logic [23:0]       ColDood  = 24'h00FF00;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StResolve,
    StEmit
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic              rd_q, rd_d;
  logic              hit_q, hit_d;
  logic [31:0]       x_q, x_d;
  logic [31:0]       y_q, y_d;
  logic [31:0]       dx_q, dx_d;
  logic [31:0]       dy_q, dy_d;
  logic [31:0]       miny_q, miny_d;
  logic              pix_valid_q, pix_valid_d;
  logic [31:0]       pix_x_q, pix_x_d;
  logic [31:0]       pix_y_q, pix_y_d;
  logic [23:0]       pix_color_q, pix_color_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              blk_rd_c;
  logic [ADDR_W-1:0] blk_addr_c;

  logic              blk_match;
  logic              dhit;
  logic              final_hit;

  // Entry read last cycle is compared now; the subtraction form avoids blk_x+width wrap.
  assign blk_match = rd_q && blk_active && (blk_y == y_q) && (x_q >= blk_x) &&
                     ((x_q - blk_x) < BlkW);
  // Screen-space doodle row wraps mod 2^32 when the camera is above the doodle.
  assign dhit      = (dx_q == x_q) && ((dy_q - miny_q) == y_q);
  assign final_hit = hit_q | blk_match;

  // Next-state, read-port and pixel-register logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    hit_d       = hit_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    miny_d      = miny_q;
    pix_valid_d = pix_valid_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    blk_rd_c    = 1'b0;
    blk_addr_c  = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          dx_d    = doodleX;
          dy_d    = doodleY;
          miny_d  = minY;
          x_d     = '0;
          y_d     = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = StFetch;
        end
      end

      StFetch: begin
        blk_rd_c   = 1'b1;
        blk_addr_c = k_q;
        hit_d      = (k_q == '0) ? 1'b0 : (hit_q | blk_match);
        if (k_q == LastK) begin
          k_d     = '0;
          state_d = StResolve;
        end else begin
          k_d = k_q + ADDR_W'(1);
        end
      end

      StResolve: begin
        pix_valid_d = 1'b1;
        pix_x_d     = x_q;
        pix_y_d     = y_q;
        if (dhit) begin
          pix_color_d = ColDood;
        end else if (final_hit) begin
          pix_color_d = ColBlock;
        end else begin
          pix_color_d = ColBkgnd;
        end
        state_d = StEmit;
      end

      StEmit: begin
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          if (x_q == XLast) begin
            x_d = '0;
            if (y_q == YLast) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = StIdle;
            end else begin
              y_d     = y_q + 32'd1;
              state_d = StFetch;
            end
          end else begin
            x_d     = x_q + 32'd1;
            state_d = StFetch;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    rd_d = blk_rd_c;
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      k_q         <= '0;
      rd_q        <= 1'b0;
      hit_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      miny_q      <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      rd_q        <= rd_d;
      hit_q       <= hit_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      miny_q      <= miny_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign blk_rd     = blk_rd_c;
  assign blk_addr   = blk_addr_c;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_color  = pix_color_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_render_scan_scheduler.sv
// Bench for render_scan_scheduler on a 4x2 screen with a 2-entry block table: directed
// frames plus randomized tables, doodle positions and sink backpressure, all scored against
// a per-pixel reference model of the frame.
`timescale 1ns / 1ps

module tb_render_scan_scheduler;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int BW = 2;
  localparam int N  = 2;
  localparam int AW = 1;

  localparam logic [23:0] CBg  = 24'h0FAF0F;
  localparam logic [23:0] CBlk = 24'hFF000F;
  localparam logic [23:0] CDd  = 24'h00FF00;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   doodleX = '0, doodleY = '0, minY = '0;
  logic          blk_rd;
  logic [AW-1:0] blk_addr;
  logic [31:0]   blk_x = '0, blk_y = '0;
  logic          blk_active = 1'b0;
  logic          pix_valid;
  logic          pix_ready = 1'b1;
  logic [31:0]   pix_x, pix_y;
  logic [23:0]   pix_color;
  logic          busy, frame_done;

  always #5 clk = ~clk;

  render_scan_scheduler #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .BLOCK_WIDTH  (BW),
    .NUM_BLOCKS   (N),
    .ADDR_W       (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .doodleX   (doodleX),
    .doodleY   (doodleY),
    .minY      (minY),
    .blk_rd    (blk_rd),
    .blk_addr  (blk_addr),
    .blk_x     (blk_x),
    .blk_y     (blk_y),
    .blk_active(blk_active),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .busy      (busy),
    .frame_done(frame_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Block table contents, held constant within a frame.
  logic [31:0] tx[N];
  logic [31:0] ty[N];
  logic        ta[N];

  // Synchronous read port of the block table.
  initial forever begin
    @(posedge clk);
    if (blk_rd) begin
      blk_x      <= tx[blk_addr];
      blk_y      <= ty[blk_addr];
      blk_active <= ta[blk_addr];
    end
  end

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [23:0] c;
  } pix_t;

  pix_t exp_q[$];

  function automatic logic [23:0] ref_color(input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] dx, input logic [31:0] dy,
                                            input logic [31:0] my);
    logic hit;
    if (dx == x && (dy - my) == y) return CDd;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (ta[i] && ty[i] == y && x >= tx[i] && (x - tx[i]) < 32'(BW)) hit = 1'b1;
    end
    return hit ? CBlk : CBg;
  endfunction

  task automatic build_frame(input logic [31:0] dx, input logic [31:0] dy,
                             input logic [31:0] my);
    pix_t p;
    exp_q.delete();
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        p.x = 32'(xx);
        p.y = 32'(yy);
        p.c = ref_color(32'(xx), 32'(yy), dx, dy, my);
        exp_q.push_back(p);
      end
    end
  endtask

  // Sink backpressure: 0 = always ready, 1 = random, 2 = 5-cycle stall at pixel (2,0).
  int ready_mode = 0;
  int stall_cnt  = 0;

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      1: pix_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (pix_valid && pix_x == 32'd2 && pix_y == 32'd0 && stall_cnt < 5) begin
          pix_ready = 1'b0;
          stall_cnt++;
        end else begin
          pix_ready = 1'b1;
        end
      end
      default: pix_ready = 1'b1;
    endcase
  end

  int          done_cnt = 0;
  int          pix_cnt  = 0;
  logic        wait_prev = 1'b0;
  logic [31:0] hx, hy;
  logic [23:0] hc;

  // Scoreboard: pixel order/content, output hold while stalled, no reads while emitting.
  initial forever begin
    pix_t e;
    @(negedge clk);
    if (frame_done) done_cnt++;
    if (wait_prev && !reset) begin
      check("hold_valid", pix_valid, 1);
      check("hold_x", pix_x, hx);
      check("hold_y", pix_y, hy);
      check("hold_color", pix_color, hc);
    end
    if (pix_valid) check("rd_while_emit", blk_rd, 0);
    wait_prev = pix_valid && !pix_ready;
    hx = pix_x;
    hy = pix_y;
    hc = pix_color;
    if (pix_valid && pix_ready) begin
      pix_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pix_x", pix_x, e.x);
        check("pix_y", pix_y, e.y);
        check("pix_color", pix_color, e.c);
      end
    end
  end

  task automatic start_frame(input logic [31:0] dx, input logic [31:0] dy,
                             input logic [31:0] my);
    int c;
    build_frame(dx, dy, my);
    @(posedge clk);
    #1;
    doodleX = dx;
    doodleY = dy;
    minY    = my;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!pix_valid && c < 50);
    check("first_valid_latency", c, N + 1);
    check("busy_running", busy, 1);
  endtask

  task automatic finish_frame(input int d0, input int p0);
    int c;
    c = 0;
    while (done_cnt == d0 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("frame_timeout", (c >= 2000), 0);
    repeat (6) @(negedge clk);
    check("frame_done_count", done_cnt - d0, 1);
    check("pixel_count", pix_cnt - p0, W * H);
    check("busy_after", busy, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic run_frame(input logic [31:0] dx, input logic [31:0] dy,
                           input logic [31:0] my, input bit restart);
    int d0, p0;
    d0 = done_cnt;
    p0 = pix_cnt;
    start_frame(dx, dy, my);
    if (restart) begin
      repeat (5) @(posedge clk);
      #1;
      start   = 1'b1;
      doodleX = dx + 32'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    finish_frame(d0, p0);
  endtask

  task automatic clear_table();
    for (int i = 0; i < N; i++) begin
      tx[i] = '0;
      ty[i] = '0;
      ta[i] = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, pix_valid, 0);
    check({tag, "_x"}, pix_x, 0);
    check({tag, "_y"}, pix_y, 0);
    check({tag, "_color"}, pix_color, 0);
    check({tag, "_rd"}, blk_rd, 0);
    check({tag, "_addr"}, blk_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, frame_done, 0);
  endtask

  initial begin
    int   c;
    int   d0;
    logic found;
    logic [31:0] xs[7];
    xs[0] = 32'd0; xs[1] = 32'd1; xs[2] = 32'd2; xs[3] = 32'd3; xs[4] = 32'd4;
    xs[5] = 32'hFFFF_FFFF; xs[6] = 32'hFFFF_FFFE;

    clear_table();
    #2 reset = 1'b1;
    #1 check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: empty table, doodle off-screen.
    run_frame(32'd9, 32'd0, 32'd0, 1'b0);

    // 2: one block at (1,0), then an x that would wrap if blk_x+width were formed.
    ta[0] = 1'b1; tx[0] = 32'd1; ty[0] = 32'd0;
    run_frame(32'd9, 32'd0, 32'd0, 1'b0);
    tx[0] = 32'hFFFF_FFFF;
    run_frame(32'd9, 32'd0, 32'd0, 1'b0);

    // 3: doodle over the block, then camera above doodle (no doodle pixel).
    tx[0] = 32'd1;
    run_frame(32'd1, 32'd5, 32'd5, 1'b0);
    run_frame(32'd1, 32'd2, 32'd3, 1'b0);

    // 4: sink stalls 5 cycles at pixel (2,0).
    stall_cnt  = 0;
    ready_mode = 2;
    run_frame(32'd1, 32'd5, 32'd5, 1'b0);
    check("stall_cycles", stall_cnt, 5);
    ready_mode = 0;

    // 5: start and doodleX changed while busy.
    run_frame(32'd2, 32'd1, 32'd0, 1'b1);

    // 6: reset while pixel (1,1) is pending.
    build_frame(32'd3, 32'd0, 32'd0);
    start_frame(32'd3, 32'd0, 32'd0);
    found = 1'b0;
    c = 0;
    while (!found && c < 500) begin
      @(posedge clk);
      #1;
      c++;
      if (pix_valid && pix_x == 32'd1 && pix_y == 32'd1) found = 1'b1;
    end
    check("reach_pixel_1_1", found, 1);
    reset = 1'b1;
    #1 check_outputs_zero("midreset");
    d0 = done_cnt;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    repeat (20) @(negedge clk);
    check("no_done_after_reset", done_cnt - d0, 0);
    check("idle_after_reset", busy, 0);
    run_frame(32'd0, 32'd1, 32'd0, 1'b0);

    // Randomized tables, doodle positions and backpressure.
    ready_mode = 1;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < N; i++) begin
        tx[i] = xs[$urandom_range(0, 6)];
        ty[i] = 32'($urandom_range(0, 2));
        ta[i] = 1'($urandom_range(0, 1));
      end
      run_frame(32'($urandom_range(0, 4)), 32'($urandom_range(0, 6)),
                32'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
